// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: EEPROM-style register file behind an I2C slave byte interface.
// Latency: read_data and ptr update 1 clk after the strobe or flag that moves them.
// Backpressure: none; every strobe is consumed on the cycle it arrives. The slave paces reads.
//
// Ports:
//   clk, rst        system clock; synchronous active-high reset
//   hitar, i2c_rw   slave address match (level) and transfer direction
//   flag_start / flag_restart / flag_stop   one-cycle bus condition pulses
//   write_data, write_en   received data byte and its strobe (address byte excluded)
//   read_en         slave has consumed read_data into its shifter
//   read_data       registered byte at the current pointer
//   ptr, busy       pointer visibility and "transfer in progress"
//
// Optional write protect, enabled by defining I2C_REG_BANK_WP_EN. It adds:
//   wp      while high, data writes are dropped but the pointer still advances
//   wp_err  one-cycle pulse for each dropped write
//
// Protocol: the first byte of a write transfer loads the pointer. Later bytes
// are stored at the pointer, which then auto-increments. Reads are served from
// the pointer, which auto-increments on each read_en. The pointer wraps modulo
// DEPTH and survives STOP, so a bare read continues from the current address.

module i2c_reg_bank #(
    parameter int         DEPTH    = 16,     // power of two, 2..256
    parameter int         PTR_W    = 4,      // must equal log2(DEPTH)
    parameter logic [7:0] INIT_VAL = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hitar,
    input  logic             i2c_rw,
    input  logic             flag_start,
    input  logic             flag_restart,
    input  logic             flag_stop,
    input  logic [7:0]       write_data,
    input  logic             write_en,
    input  logic             read_en,
`ifdef I2C_REG_BANK_WP_EN
    input  logic             wp,
    output logic             wp_err,
`endif
    output logic [7:0]       read_data,
    output logic [PTR_W-1:0] ptr,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PTR     = 2'd1;
    localparam logic [1:0] ST_DATA_WR = 2'd2;
    localparam logic [1:0] ST_DATA_RD = 2'd3;

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [7:0]       regs_q [DEPTH];
    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [7:0]       read_data_q, read_data_d;
    logic             busy_q;

    // Set by reset, cleared once hitar is seen low. This keeps a transfer that
    // was in flight when reset hit from being picked up halfway through. The
    // bank rejoins the bus only on a fresh address match.
    logic             blocked_q, blocked_d;

    logic             wr_fire;     // store write_data at ptr_q this cycle
    logic [1:0]       entry_state; // where an address phase lands us
    logic             in_xfer;

`ifdef I2C_REG_BANK_WP_EN
    logic             wr_drop;
    logic             wp_err_q;
`endif

    assign in_xfer = (state_q != ST_IDLE);

    // Decision made at IDLE. A restart, or a START seen mid-transfer, reuses it
    // on the same cycle.
    always_comb begin
        entry_state = ST_IDLE;
        if (hitar && !blocked_q) begin
            entry_state = i2c_rw ? ST_DATA_RD : ST_PTR;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_fire   = 1'b0;
        blocked_d = blocked_q & hitar;
`ifdef I2C_REG_BANK_WP_EN
        wr_drop   = 1'b0;
`endif

        // Datapath effects depend only on the current state. They take effect
        // even when a STOP, restart or hitar drop arrives on the same cycle.
        // Strobes that do not match the current state are ignored.
        case (state_q)
            ST_PTR: begin
                if (write_en) begin
                    ptr_d = write_data[PTR_W-1:0];
                end
            end
            ST_DATA_WR: begin
                if (write_en) begin
                    ptr_d = ptr_q + PTR_ONE;
`ifdef I2C_REG_BANK_WP_EN
                    wr_fire = !wp;
                    wr_drop = wp;
`else
                    wr_fire = 1'b1;
`endif
                end
            end
            ST_DATA_RD: begin
                if (read_en) begin
                    ptr_d = ptr_q + PTR_ONE;
                end
            end
            default: begin
            end
        endcase

        // Control: STOP wins, then restart, then abort on loss of address match.
        if (flag_stop) begin
            state_d = ST_IDLE;
        end else if (flag_restart || (flag_start && in_xfer)) begin
            state_d = entry_state;
        end else if (in_xfer && !hitar) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = entry_state;
                ST_PTR:  if (write_en) state_d = ST_DATA_WR;
                default: begin
                end
            endcase
        end
    end

    // read_data follows the post-update pointer. A write always goes to ptr_q,
    // and in that same cycle the pointer moves off it (DEPTH >= 2). So the
    // location addressed by ptr_d never changes this cycle, and regs_q is
    // already correct for it.
    always_comb begin
        read_data_d = regs_q[ptr_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            read_data_q <= INIT_VAL;
            busy_q      <= 1'b0;
            blocked_q   <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= INIT_VAL;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            read_data_q <= read_data_d;
            busy_q      <= (state_d != ST_IDLE);
            blocked_q   <= blocked_d;
            if (wr_fire) begin
                regs_q[ptr_q] <= write_data;
            end
        end
    end

`ifdef I2C_REG_BANK_WP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_err_q <= 1'b0;
        end else begin
            wp_err_q <= wr_drop;
        end
    end

    assign wp_err = wp_err_q;
`endif

    assign read_data = read_data_q;
    assign ptr       = ptr_q;
    assign busy      = busy_q;

endmodule
